// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of an async FIFO. Throttles on
// full/almost_full and routes each wr_ack/wr_err back to its requester.
module fifo_wr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                     wr_clk,
  input  logic                     clear_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       req_err,
  output logic [WIDTH-1:0]         din,
  output logic                     wr_en,
  input  logic                     full,
  input  logic                     almost_full,
  input  logic                     wr_ack,
  input  logic                     wr_err,
  output logic [7:0]               err_count,
  output logic                     proto_err
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONEHOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0]     LAST_INIT = IDW'(NUM_REQ - 1);

  // First asserted valid bit searched upward from last+1, wrapping.
  function automatic logic [IDW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDW-1:0]     last);
    logic [IDW-1:0] pick;
    int             pos;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = int'(last) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (valid[i] && (pos == i)) pick = IDW'(i);
      end
    end
    return pick;
  endfunction

  logic [WIDTH-1:0]   r_din;
  logic               r_wr_en;
  logic [IDW-1:0]     r_id_q;
  logic [IDW-1:0]     r_id_qq;
  logic               r_pend_q;
  logic [IDW-1:0]     r_last;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [NUM_REQ-1:0] r_req_err;
  logic [7:0]         r_err_count;
  logic               r_proto_err;
  logic               r_fresh;

  logic [WIDTH-1:0]   w_word [NUM_REQ];
  logic [NUM_REQ-1:0] w_ack_route;
  logic [NUM_REQ-1:0] w_err_route;
  logic               w_issue_ok;
  logic               w_xfer;
  logic [IDW-1:0]     w_pick;
  logic               w_proto_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_word[gi]      = req_data[gi*WIDTH +: WIDTH];
      assign w_ack_route[gi] = wr_ack & r_pend_q & (r_id_qq == IDW'(gi));
      assign w_err_route[gi] = wr_err & r_pend_q & (r_id_qq == IDW'(gi));
    end
  endgenerate

  // Near-full: allow a new write only when none is already on the port.
  assign w_issue_ok = clear_n & ~full & (~almost_full | ~r_wr_en);
  assign w_pick     = f_rr_pick(req_valid, r_last);
  assign w_xfer     = w_issue_ok & (|req_valid);
  assign req_ready  = w_xfer ? (ONEHOT0 << w_pick) : '0;

  // Responses in the first cycle after reset may belong to forgotten writes.
  assign w_proto_hit = ~r_fresh & ((((wr_ack | wr_err) & ~r_pend_q)) | (wr_ack & wr_err));

  always_ff @(posedge wr_clk) begin
    if (!clear_n) begin
      r_din       <= '0;
      r_wr_en     <= 1'b0;
      r_id_q      <= '0;
      r_id_qq     <= '0;
      r_pend_q    <= 1'b0;
      r_last      <= LAST_INIT;
      r_req_ack   <= '0;
      r_req_err   <= '0;
      r_err_count <= '0;
      r_proto_err <= 1'b0;
      r_fresh     <= 1'b1;
    end else begin
      r_pend_q  <= r_wr_en;
      r_id_qq   <= r_id_q;
      r_req_ack <= w_ack_route;
      r_req_err <= w_err_route;
      r_fresh   <= 1'b0;
      if (w_xfer) begin
        r_din   <= w_word[w_pick];
        r_wr_en <= 1'b1;
        r_id_q  <= w_pick;
        r_last  <= w_pick;
      end else begin
        r_wr_en <= 1'b0;
      end
      if (wr_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_proto_hit) r_proto_err <= 1'b1;
    end
  end

  assign din       = r_din;
  assign wr_en     = r_wr_en;
  assign req_ack   = r_req_ack;
  assign req_err   = r_req_err;
  assign err_count = r_err_count;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a transaction-level arbiter and
// FIFO reference model (occupancy counter, round-robin pointer, response tags).
module tb_fifo_wr_arbiter;
  localparam int W     = 8;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam logic [N-1:0] ONE = 1;

  logic           clk = 1'b0;
  logic           clear_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready, req_ack, req_err;
  logic [W-1:0]   din;
  logic           wr_en;
  logic           full, almost_full, wr_ack, wr_err;
  logic [7:0]     err_count;
  logic           proto_err;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .wr_clk(clk), .clear_n(clear_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_ack(req_ack), .req_err(req_err), .din(din),
    .wr_en(wr_en), .full(full), .almost_full(almost_full), .wr_ack(wr_ack),
    .wr_err(wr_err), .err_count(err_count), .proto_err(proto_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  int           m_last = N - 1;
  bit           m_wr_en = 1'b0;
  logic [W-1:0] m_din = '0;
  int           m_id = 0;
  bit           resp_valid = 1'b0;
  int           resp_id = 0;
  logic [N-1:0] exp_ack = '0, exp_err = '0, m_ready = '0, obs_ready = '0;
  int           m_errcnt = 0;
  bit           m_proto = 1'b0, m_fresh = 1'b0;
  int           fifo_cnt = 0;
  bit           drain = 1'b1, force_err = 1'b0, inject_ack = 1'b0;

  task automatic update_flags();
    full        = (fifo_cnt >= DEPTH);
    almost_full = (fifo_cnt >= DEPTH - 1);
  endtask

  // One clock: grant prediction before the edge, model + FIFO update after it.
  task automatic tick();
    int g, wid;
    bit iss, clr, we, a_in, e_in;
    @(negedge clk);
    iss = clear_n && !full && (!almost_full || !m_wr_en);
    g = -1;
    if (iss) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    m_ready   = (g >= 0) ? (ONE << g) : '0;
    obs_ready = req_ready;
    clr = clear_n; we = m_wr_en; wid = m_id; a_in = wr_ack; e_in = wr_err;
    @(posedge clk);
    #1;
    cyc++;
    if (!clr) begin
      m_wr_en = 0; m_din = '0; m_last = N - 1; m_id = 0;
      exp_ack = '0; exp_err = '0; m_errcnt = 0; m_proto = 0; m_fresh = 1;
    end else begin
      exp_ack = (a_in && resp_valid) ? (ONE << resp_id) : '0;
      exp_err = (e_in && resp_valid) ? (ONE << resp_id) : '0;
      if (e_in && m_errcnt < 255) m_errcnt++;
      if (!m_fresh && (((a_in || e_in) && !resp_valid) || (a_in && e_in))) m_proto = 1;
      m_fresh = 0;
      if (g >= 0) begin
        m_din = req_data[g*W +: W]; m_wr_en = 1; m_id = g; m_last = g;
        $display("cyc=%0d grant=%0d data=%h fifo_cnt=%0d", cyc, g, m_din, fifo_cnt);
      end else begin
        m_wr_en = 0;
      end
    end
    // FIFO model: response to the write it sampled at this edge
    resp_valid = we && clr;
    resp_id    = wid;
    wr_ack = inject_ack;
    wr_err = 1'b0;
    if (we) begin
      if (force_err || fifo_cnt >= DEPTH) wr_err = 1'b1;
      else begin wr_ack = 1'b1; fifo_cnt++; end
    end
    if (drain && fifo_cnt > 0) fifo_cnt--;
    update_flags();
  endtask

  task automatic do_reset();
    clear_n = 0; force_err = 0; inject_ack = 0; drain = 1;
    tick(); tick();
    clear_n = 1;
  endtask

  task automatic test_reset();
    clear_n = 0; req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (obs_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      total++; if (din !== '0) begin bad++; $display("FAIL reset_din: got %h want 0", din); end
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto: got %b want 0", proto_err); end
      total++; if ((req_ack | req_err) !== '0) begin bad++; $display("FAIL reset_resp: got %b/%b want 0", req_ack, req_err); end
    end
    clear_n = 1;
    tick();
    total++; if (obs_ready !== 4'b0001) begin bad++; $display("FAIL first_grant: got %b want 0001", obs_ready); end
    total++; if (din !== req_data[W-1:0]) begin bad++; $display("FAIL first_din: got %h want %h", din, req_data[W-1:0]); end
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL first_wr_en: got %b want 1", wr_en); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'hA0 + i);
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (obs_ready !== (ONE << (i % N))) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, obs_ready, ONE << (i % N)); end
      total++; if (din !== W'(8'hA0 + (i % N)) || wr_en !== 1'b1) begin bad++; $display("FAIL rr_din[%0d]: got %h/%b want %h/1", i, din, wr_en, 8'hA0 + (i % N)); end
      if (i >= 2) begin
        total++; if (req_ack !== (ONE << ((i - 2) % N))) begin bad++; $display("FAIL rr_ack[%0d]: got %b want %b", i, req_ack, ONE << ((i - 2) % N)); end
      end
    end
  endtask

  task automatic test_sparse();
    int exp_g [6] = '{1, 3, 1, 3, 3, 1};
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    for (int i = 0; i < 6; i++) begin
      req_valid = (i == 4) ? 4'b1000 : 4'b1010;
      tick();
      total++; if (obs_ready !== (ONE << exp_g[i])) begin bad++; $display("FAIL sparse_grant[%0d]: got %b want %b", i, obs_ready, ONE << exp_g[i]); end
      total++; if (din !== m_din) begin bad++; $display("FAIL sparse_din[%0d]: got %h want %h", i, din, m_din); end
    end
  endtask

  task automatic test_near_full();
    int acks = 0, errs = 0;
    bit exp_we [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    do_reset();
    drain = 0; fifo_cnt = 14; update_flags();
    req_valid = 4'b0001; req_data[W-1:0] = W'($urandom);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_ack[0] === 1'b1) acks++;
      if (wr_err) errs++;
      total++; if (wr_en !== exp_we[i]) begin bad++; $display("FAIL nf_wr_en[%0d]: got %b want %b", i, wr_en, exp_we[i]); end
    end
    total++; if (acks !== 2) begin bad++; $display("FAIL nf_ack_count: got %0d want 2", acks); end
    total++; if (errs !== 0) begin bad++; $display("FAIL nf_overflow: got %0d wr_err want 0", errs); end
    // Drain slowly: writes may only be spaced while near full
    for (int i = 0; i < 10; i++) begin
      drain = i[0];
      tick();
      total++; if (wr_en !== m_wr_en || obs_ready !== m_ready) begin bad++; $display("FAIL nf_drain[%0d]: got %b/%b want %b/%b", i, wr_en, obs_ready, m_wr_en, m_ready); end
      total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL nf_drain_err[%0d]: got wr_err=1 want 0", i); end
    end
  endtask

  task automatic test_error_routing();
    do_reset();
    req_valid = 4'b0100; req_data[2*W +: W] = W'($urandom); force_err = 1;
    tick();
    req_valid = '0;
    tick(); tick();
    total++; if (req_err !== 4'b0100 || req_ack !== '0) begin bad++; $display("FAIL err_route: got err=%b ack=%b want err=0100 ack=0", req_err, req_ack); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL err_count1: got %0d want 1", err_count); end
    tick();
    total++; if (req_err !== '0) begin bad++; $display("FAIL err_pulse: got %b want 0", req_err); end
    req_valid = '1;
    for (int i = 0; i < 305; i++) begin
      for (int r = 0; r < N; r++) req_data[r*W +: W] = W'($urandom);
      tick();
      total++; if (err_count !== 8'(m_errcnt) || req_err !== exp_err) begin bad++; $display("FAIL err_many[%0d]: got %0d/%b want %0d/%b", i, err_count, req_err, m_errcnt, exp_err); end
    end
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    force_err = 0;
  endtask

  task automatic test_protocol();
    do_reset();
    req_valid = '0; inject_ack = 1;
    tick();
    inject_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky[%0d]: got %b want 1", i, proto_err); end
    end
    do_reset();
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clear: got %b want 0", proto_err); end
    req_valid = 4'b0001; req_data[W-1:0] = W'($urandom);
    tick();
    req_valid = '0; clear_n = 0;
    tick();
    clear_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (req_ack !== '0 || req_err !== '0) begin bad++; $display("FAIL rst_drop_ack[%0d]: got %b/%b want 0", i, req_ack, req_err); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_drop_proto[%0d]: got %b want 0", i, proto_err); end
    end
  endtask

  task automatic test_random();
    do_reset();
    fifo_cnt = 10; update_flags();
    for (int i = 0; i < 250; i++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++) req_data[r*W +: W] = W'($urandom);
      drain     = ($urandom_range(0, 1) == 1);
      force_err = ($urandom_range(0, 19) == 0);
      clear_n   = ($urandom_range(0, 39) != 0);
      tick();
      total++; if (obs_ready !== m_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, m_ready); end
      total++; if (wr_en !== m_wr_en || din !== m_din) begin bad++; $display("FAIL rnd_write[%0d]: got %b/%h want %b/%h", i, wr_en, din, m_wr_en, m_din); end
      total++; if (req_ack !== exp_ack || req_err !== exp_err) begin bad++; $display("FAIL rnd_resp[%0d]: got %b/%b want %b/%b", i, req_ack, req_err, exp_ack, exp_err); end
      total++; if (err_count !== 8'(m_errcnt) || proto_err !== m_proto) begin bad++; $display("FAIL rnd_status[%0d]: got %0d/%b want %0d/%b", i, err_count, proto_err, m_errcnt, m_proto); end
    end
    clear_n = 1; force_err = 0;
  endtask

  initial begin
    clear_n = 0; req_valid = '0; req_data = '0;
    wr_ack = 0; wr_err = 0; update_flags();
    test_reset();
    test_round_robin();
    test_sparse();
    test_near_full();
    test_error_routing();
    test_protocol();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
